// File: rtl/pulse_width_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_width_encoder
//  Purpose  : Converts the modulated 16-bit intensity stream into a 9-bit
//             pulse width via an external duty-table RAM (2-cycle read).
//             Phase and frame index travel alongside each beat with a fixed
//             3-cycle latency, and the frame index of every beat is tracked.
//  Options  : PWE_FULL_WIDTH_EN - intensity 0xFE01 forces a full-on pulse
//             width of 256 and bypasses the table for that beat.
//  Revision : 1.0 - initial release
// ============================================================================
module pulse_width_encoder #(
    parameter int DEPTH = 249
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        DIN_VALID,
    input  logic [15:0] INTENSITY_IN,
    input  logic [7:0]  PHASE_IN,
    output logic [14:0] TABLE_ADDR,
    input  logic [7:0]  TABLE_DATA,
    output logic        DOUT_VALID,
    output logic [8:0]  PULSE_WIDTH_OUT,
    output logic [7:0]  PHASE_OUT,
    output logic        DOUT_LAST,
    output logic        FRAME_ERR,
    output logic [7:0]  DEBUG_IDX
);

    localparam logic [7:0]  c_LAST_IDX  = 8'(DEPTH - 1);
    localparam logic [15:0] c_FULL_CODE = 16'hFE01;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Side information carried with each beat while the table read is in flight
    typedef struct packed {
        logic       valid;
        logic       last;
        logic [7:0] idx;
        logic [7:0] phase;
    } beat_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_idx;
    logic [7:0]  w_idx_next;
    logic [7:0]  w_tag;
    logic        w_err_set;

    beat_t       w_beat_in;
    beat_t       r_s1;
    beat_t       r_s2;
    beat_t       r_s3;
    logic [8:0]  w_pulse_width;

    logic [14:0] r_table_addr;
    logic        r_dout_valid;
    logic [8:0]  r_pulse_width;
    logic [7:0]  r_phase;
    logic        r_last;
    logic        r_frame_err;
    logic [7:0]  r_debug_idx;

    // Frame index FSM: next state, next index, tag for the incoming beat
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_tag        = r_idx;
        w_err_set    = 1'b0;
        if (DIN_VALID) begin
            // IDLE always holds idx 0, so both states tag the current idx
            if (r_idx == c_LAST_IDX) begin
                w_idx_next   = 8'd0;
                w_state_next = ST_IDLE;
            end else begin
                w_idx_next   = r_idx + 8'd1;
                w_state_next = ST_RUN;
            end
        end else if (r_state == ST_RUN) begin
            // A gap inside an open frame truncates it
            w_err_set    = 1'b1;
            w_idx_next   = 8'd0;
            w_state_next = ST_IDLE;
        end
    end

    // FSM state and index registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_idx   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // Sticky truncation flag, cleared only by reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_frame_err <= 1'b0;
        end else if (w_err_set) begin
            r_frame_err <= 1'b1;
        end
    end

    // Table address follows the last valid intensity and holds otherwise
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_table_addr <= 15'd0;
        end else if (DIN_VALID) begin
            r_table_addr <= INTENSITY_IN[15:1];
        end
    end

    always_comb begin
        w_beat_in       = '0;
        w_beat_in.valid = DIN_VALID;
        w_beat_in.last  = DIN_VALID && (w_tag == c_LAST_IDX);
        w_beat_in.idx   = w_tag;
        w_beat_in.phase = PHASE_IN;
    end

    // Side-information delay line matching the table read latency
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= w_beat_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

`ifdef PWE_FULL_WIDTH_EN
    logic [2:0] r_full_pipe;

    // Full-on flag decoded at the input and carried with its beat
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_full_pipe <= 3'b000;
        end else begin
            r_full_pipe <= {r_full_pipe[1:0], (INTENSITY_IN == c_FULL_CODE)};
        end
    end

    // Full-on beats override whatever the table returns
    always_comb begin
        w_pulse_width = {1'b0, TABLE_DATA};
        if (r_full_pipe[2]) begin
            w_pulse_width = 9'd256;
        end
    end
`else
    // The table only sees intensity[15:1]; the LSB has no other consumer
    logic w_unused_lsb;
    assign w_unused_lsb = INTENSITY_IN[0] ^ (c_FULL_CODE[0]);

    // Pulse width comes straight from the table
    always_comb begin
        w_pulse_width = {1'b0, TABLE_DATA};
    end
`endif

    // Output registers: data fields hold when no beat is presented
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_dout_valid  <= 1'b0;
            r_last        <= 1'b0;
            r_pulse_width <= 9'd0;
            r_phase       <= 8'd0;
            r_debug_idx   <= 8'd0;
        end else begin
            r_dout_valid <= r_s3.valid;
            r_last       <= r_s3.valid && r_s3.last;
            if (r_s3.valid) begin
                r_pulse_width <= w_pulse_width;
                r_phase       <= r_s3.phase;
                r_debug_idx   <= r_s3.idx;
            end
        end
    end

    assign TABLE_ADDR      = r_table_addr;
    assign DOUT_VALID      = r_dout_valid;
    assign PULSE_WIDTH_OUT = r_pulse_width;
    assign PHASE_OUT       = r_phase;
    assign DOUT_LAST       = r_last;
    assign FRAME_ERR       = r_frame_err;
    assign DEBUG_IDX       = r_debug_idx;

endmodule
`default_nettype wire

// File: tb/tb_pulse_width_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pulse_width_encoder
//  Purpose  : Self-checking bench for pulse_width_encoder. A duty-table RAM
//             model with 2-cycle read latency feeds the DUT; a behavioural
//             reference predicts every output cycle. Honours
//             PWE_FULL_WIDTH_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_width_encoder;

    localparam int DEPTH = 249;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        DIN_VALID;
    logic [15:0] INTENSITY_IN;
    logic [7:0]  PHASE_IN;
    logic [14:0] TABLE_ADDR;
    logic [7:0]  TABLE_DATA = 8'd0;
    logic        DOUT_VALID;
    logic [8:0]  PULSE_WIDTH_OUT;
    logic [7:0]  PHASE_OUT;
    logic        DOUT_LAST;
    logic        FRAME_ERR;
    logic [7:0]  DEBUG_IDX;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_last   = 0;

    always #5 CLK = ~CLK;

    pulse_width_encoder #(.DEPTH(DEPTH)) dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .DIN_VALID       (DIN_VALID),
        .INTENSITY_IN    (INTENSITY_IN),
        .PHASE_IN        (PHASE_IN),
        .TABLE_ADDR      (TABLE_ADDR),
        .TABLE_DATA      (TABLE_DATA),
        .DOUT_VALID      (DOUT_VALID),
        .PULSE_WIDTH_OUT (PULSE_WIDTH_OUT),
        .PHASE_OUT       (PHASE_OUT),
        .DOUT_LAST       (DOUT_LAST),
        .FRAME_ERR       (FRAME_ERR),
        .DEBUG_IDX       (DEBUG_IDX)
    );

    // Duty-table RAM: data valid two cycles after the address is presented
    logic [7:0] tbl [32768];
    logic [7:0] rd_d1 = 8'd0;
    always @(posedge CLK) begin
        rd_d1      <= tbl[TABLE_ADDR];
        TABLE_DATA <= rd_d1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] ref_pw(input logic [15:0] inten);
`ifdef PWE_FULL_WIDTH_EN
        if (inten == 16'hFE01) return 9'd256;
`endif
        return {1'b0, tbl[inten >> 1]};
    endfunction

    // Reference: what each input beat must look like three edges later
    typedef struct packed {
        logic       v;
        logic       last;
        logic [8:0] pw;
        logic [7:0] ph;
        logic [7:0] idx;
    } exp_t;

    exp_t hist [3];
    exp_t exp_cur;
    int   pos;
    bit   exp_err;
    int   exp_pw;
    int   exp_ph;

    always @(posedge CLK or negedge RST_N) begin
        exp_t nb;
        if (!RST_N) begin
            for (int k = 0; k < 3; k++) hist[k] <= '0;
            exp_cur <= '0;
            pos     <= 0;
            exp_err <= 1'b0;
            exp_pw  <= 0;
            exp_ph  <= 0;
        end else begin
            nb = '0;
            if (DIN_VALID) begin
                nb.v    = 1'b1;
                nb.idx  = 8'(pos);
                nb.last = (pos == DEPTH - 1);
                nb.ph   = PHASE_IN;
                nb.pw   = ref_pw(INTENSITY_IN);
                pos <= (pos == DEPTH - 1) ? 0 : pos + 1;
            end else begin
                if (pos != 0) exp_err <= 1'b1;
                pos <= 0;
            end
            exp_cur <= hist[2];
            hist[2] <= hist[1];
            hist[1] <= hist[0];
            hist[0] <= nb;
            if (hist[2].v) begin
                exp_pw <= int'(hist[2].pw);
                exp_ph <= int'(hist[2].ph);
            end
        end
    end

    // Cycle-by-cycle comparison against the reference
    always @(negedge CLK) begin
        if (RST_N) begin
            check("dout_valid", DOUT_VALID, exp_cur.v);
            check("dout_last", DOUT_LAST, exp_cur.last);
            check("frame_err", FRAME_ERR, exp_err);
            check("pulse_width", PULSE_WIDTH_OUT, exp_pw);
            check("phase_out", PHASE_OUT, exp_ph);
            if (exp_cur.v && DOUT_VALID) check("debug_idx", DEBUG_IDX, exp_cur.idx);
            if (DOUT_VALID) n_valid++;
            if (DOUT_LAST) n_last++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            DIN_VALID = 1'b0;
        end
    endtask

    // mode 0: intensity 2*i / phase i, 1: random, 2: full-scale 0xFE01
    task automatic send_frame(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            DIN_VALID = 1'b1;
            case (mode)
                0: begin
                    INTENSITY_IN = 16'(2 * i);
                    PHASE_IN     = 8'(i);
                end
                1: begin
                    INTENSITY_IN = 16'($urandom_range(0, 32'hFE01));
                    PHASE_IN     = 8'($urandom);
                end
                default: begin
                    INTENSITY_IN = 16'hFE01;
                    PHASE_IN     = 8'h5A;
                end
            endcase
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, TABLE_ADDR, 0);
        check({tag, "_valid"}, DOUT_VALID, 0);
        check({tag, "_pw"}, PULSE_WIDTH_OUT, 0);
        check({tag, "_phase"}, PHASE_OUT, 0);
        check({tag, "_last"}, DOUT_LAST, 0);
        check({tag, "_err"}, FRAME_ERR, 0);
        check({tag, "_idx"}, DEBUG_IDX, 0);
    endtask

    initial begin
        int v0;
        int l0;
        bit seen;

        RST_N        = 1'b0;
        DIN_VALID    = 1'b0;
        INTENSITY_IN = 16'd0;
        PHASE_IN     = 8'd0;
        for (int a = 0; a < 32768; a++) tbl[a] = 8'(a);
        tbl[15'h7F00] = 8'hAB;
        tbl[15'h7FFF] = 8'hAB;

        @(negedge CLK);
        check_all_zero("reset");
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        idle(3);

        // Single identity frame
        v0 = n_valid; l0 = n_last;
        send_frame(DEPTH, 0);
        idle(6);
        check("frame1_beats", n_valid - v0, 249);
        check("frame1_lasts", n_last - l0, 1);
        check("frame1_err", FRAME_ERR, 0);

        // Two frames with no gap
        v0 = n_valid; l0 = n_last;
        send_frame(DEPTH, 0);
        send_frame(DEPTH, 0);
        idle(6);
        check("b2b_beats", n_valid - v0, 498);
        check("b2b_lasts", n_last - l0, 2);

        // Truncated frame followed by a complete one
        send_frame(100, 0);
        idle(6);
        check("trunc_err", FRAME_ERR, 1);
        v0 = n_valid; l0 = n_last;
        send_frame(DEPTH, 0);
        idle(6);
        check("after_trunc_beats", n_valid - v0, 249);
        check("after_trunc_lasts", n_last - l0, 1);
        check("trunc_err_sticky", FRAME_ERR, 1);

        // Full-scale intensity beat
        send_frame(1, 2);
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge CLK);
            DIN_VALID = 1'b0;
            #1;
            if (DOUT_VALID) begin
                seen = 1'b1;
`ifdef PWE_FULL_WIDTH_EN
                check("fe01_pw", PULSE_WIDTH_OUT, 256);
`else
                check("fe01_pw", PULSE_WIDTH_OUT, 8'hAB);
`endif
                check("fe01_phase", PHASE_OUT, 8'h5A);
            end
        end
        if (!seen) check("fe01_timeout", 0, 1);
        idle(4);

        // Reset with beats in flight
        send_frame(50, 1);
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge CLK);
        DIN_VALID = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        v0 = n_valid;
        idle(6);
        check("no_stale_beats", n_valid - v0, 0);
        v0 = n_valid; l0 = n_last;
        send_frame(DEPTH, 0);
        idle(6);
        check("post_reset_beats", n_valid - v0, 249);
        check("post_reset_lasts", n_last - l0, 1);
        check("post_reset_err", FRAME_ERR, 0);

        // Random frames, with and without gaps
        v0 = n_valid; l0 = n_last;
        for (int f = 0; f < 25; f++) begin
            send_frame(DEPTH, 1);
            idle($urandom_range(0, 3));
        end
        idle(8);
        check("random_beats", n_valid - v0, 25 * 249);
        check("random_lasts", n_last - l0, 25);
        check("random_err", FRAME_ERR, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
